// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_LEN_DEF = 8;

  // Length field must hold MAX_LEN itself, hence the extra bit.
  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  localparam int LEN_W_DEF = len_width(MAX_LEN_DEF);

  localparam logic [4:0] PAT_10010 = 5'b10010;

endpackage

// File: rtl/seq_det_core.sv
// Shift register, saturating bit count and masked pattern compare.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               sbit,
  input  logic               clr,
  input  logic               overlap,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               hit
);

  logic [MAX_LEN-1:0] shift_q;
  logic [MAX_LEN-1:0] shift_d;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN:0]   mask_ext;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   cnt_inc;

  // hit is evaluated on the post-shift value so the match can be registered
  // on the same edge that shifts in the completing bit.
  always_comb begin
    shift_d  = {shift_q[MAX_LEN-2:0], sbit};
    cnt_inc  = (cnt_q == LEN_W'(MAX_LEN)) ? cnt_q : cnt_q + LEN_W'(1);
    mask_ext = ((MAX_LEN+1)'(1) << len) - (MAX_LEN+1)'(1);
    mask     = mask_ext[MAX_LEN-1:0];
    hit      = shift_en && (cnt_inc >= len) && (((shift_d ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shift_q <= shift_d;
      cnt_q   <= (hit && !overlap) ? '0 : cnt_inc;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequence detector controller: config handshake, run FSM and match counter.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN   = 8,
  parameter int CNT_W     = 8,
  parameter int HIT_LIMIT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [MAX_LEN-1:0]     cfg_pattern,
  input  logic [$clog2(MAX_LEN):0] cfg_len,
  input  logic                   cfg_overlap,
  output logic                   cfg_err,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   data_valid,
  input  logic                   data,
  output logic                   match,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam int LEN_W = len_width(MAX_LEN);

  state_t             state, next;
  logic               loaded;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               hit;
  logic               load, err_d, go, limit_hit, len_ok;
  logic [CNT_W-1:0]   cnt_inc;

  seq_det_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (state == RUN && data_valid),
    .sbit     (data),
    .clr      (go),
    .overlap  (ovl_q),
    .len      (len_q),
    .pattern  (pat_q),
    .hit      (hit)
  );

  assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign cnt_inc   = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
  assign limit_hit = (HIT_LIMIT != 0) && hit && (cnt_inc == CNT_W'(HIT_LIMIT));

  // cfg_valid always wins over start in IDLE, legal or not.
  always_comb begin
    next  = state;
    load  = 1'b0;
    err_d = 1'b0;
    go    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          load  = len_ok;
          err_d = !len_ok;
        end else if (start && loaded) begin
          go   = 1'b1;
          next = RUN;
        end
      end
      RUN:     if (stop || limit_hit) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      loaded    <= 1'b0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      match     <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= next;
      match   <= hit;
      cfg_err <= err_d;
      if (load) begin
        loaded <= 1'b1;
        pat_q  <= cfg_pattern;
        len_q  <= cfg_len;
        ovl_q  <= cfg_overlap;
      end
      if (go)       match_cnt <= '0;
      else if (hit) match_cnt <= cnt_inc;
    end
  end

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: unlimited and HIT_LIMIT=2 instances share stimulus.
module tb_seq_det_ctrl;
  import seq_det_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LW      = $clog2(MAX_LEN) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_valid = 1'b0, cfg_overlap = 1'b0, start = 1'b0, stop = 1'b0;
  logic data_valid = 1'b0, data = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;

  logic m_ready, m_err, m_match, m_busy, m_done;
  logic l_ready, l_err, l_match, l_busy, l_done;
  logic [CNT_W-1:0] m_cnt, l_cnt;

  always #5 clk = ~clk;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .HIT_LIMIT(0)) u_main (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(m_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(m_err), .start(start), .stop(stop), .data_valid(data_valid),
    .data(data), .match(m_match), .match_cnt(m_cnt), .busy(m_busy), .done(m_done));

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .HIT_LIMIT(2)) u_lim (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(l_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(l_err), .start(start), .stop(stop), .data_valid(data_valid),
    .data(data), .match(l_match), .match_cnt(l_cnt), .busy(l_busy), .done(l_done));

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 running, 2 finishing; history = bits seen
  // since the run started or since the last non-overlapping match.
  int lim [2] = '{0, 2};
  int st [2];
  bit loaded [2];
  int mpat [2], mlen [2];
  bit movl [2];
  int mcnt [2];
  bit emat [2], eerr [2];
  int hist [2][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tail_match(input int k);
    int n = hist[k].size();
    if (n < mlen[k]) return 1'b0;
    for (int i = 0; i < mlen[k]; i++)
      if (hist[k][n - mlen[k] + i] != ((mpat[k] >> (mlen[k] - 1 - i)) & 1)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      st[k] = 0; loaded[k] = 0; mpat[k] = 0; mlen[k] = 0; movl[k] = 0;
      mcnt[k] = 0; emat[k] = 0; eerr[k] = 0; hist[k].delete();
    end
  endtask

  task automatic model_edge(input int k);
    emat[k] = 0;
    eerr[k] = 0;
    case (st[k])
      0: begin
        if (cfg_valid) begin
          if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
            loaded[k] = 1; mpat[k] = int'(cfg_pattern); mlen[k] = int'(cfg_len);
            movl[k] = cfg_overlap;
          end else eerr[k] = 1;
        end else if (start && loaded[k]) begin
          st[k] = 1; mcnt[k] = 0; hist[k].delete();
        end
      end
      1: begin
        if (data_valid) begin
          hist[k].push_back(int'(data));
          if (hist[k].size() > MAX_LEN) void'(hist[k].pop_front());
          if (tail_match(k)) begin
            emat[k] = 1;
            if (mcnt[k] < (1 << CNT_W) - 1) mcnt[k]++;
            if (!movl[k]) hist[k].delete();
          end
        end
        if (stop || (lim[k] != 0 && emat[k] && mcnt[k] == lim[k])) st[k] = 2;
      end
      default: st[k] = 0;
    endcase
  endtask

  task automatic check_all();
    chk("main.match", m_match, emat[0]);
    chk("main.cnt",   m_cnt,   mcnt[0]);
    chk("main.err",   m_err,   eerr[0]);
    chk("main.busy",  m_busy,  st[0] == 1);
    chk("main.done",  m_done,  st[0] == 2);
    chk("main.ready", m_ready, st[0] == 0);
    chk("lim.match",  l_match, emat[1]);
    chk("lim.cnt",    l_cnt,   mcnt[1]);
    chk("lim.err",    l_err,   eerr[1]);
    chk("lim.busy",   l_busy,  st[1] == 1);
    chk("lim.done",   l_done,  st[1] == 2);
    chk("lim.ready",  l_ready, st[1] == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask

  task automatic idle_in();
    cfg_valid = 0; start = 0; stop = 0; data_valid = 0;
  endtask

  task automatic cfg_tx(input logic [7:0] p, input int l, input bit o);
    idle_in();
    cfg_valid = 1; cfg_pattern = p; cfg_len = LW'(l); cfg_overlap = o;
    step();
    idle_in();
  endtask

  task automatic start_tx();
    idle_in(); start = 1; step(); idle_in();
  endtask

  task automatic feed(input logic [15:0] v, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        idle_in(); data = ~v[i]; step();
      end
      idle_in(); data_valid = 1; data = v[i]; step();
    end
    idle_in();
  endtask

  task automatic finish_run();
    idle_in(); stop = 1; step(); idle_in(); step(); step();
  endtask

  task automatic async_reset();
    #3;
    rst = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1;

    // 1: non-overlap 10010
    cfg_tx(8'h12, 5, 0);
    start_tx();
    feed(16'(PAT_10010), 5, 0);
    chk("t1.cnt", m_cnt, 1);
    finish_run();

    // 2: overlap vs non-overlap on 10010010
    cfg_tx(8'h12, 5, 1);
    start_tx();
    feed(16'b10010010, 8, 0);
    chk("t2.ovl_cnt", m_cnt, 2);
    finish_run();
    cfg_tx(8'h12, 5, 0);
    start_tx();
    feed(16'b10010010, 8, 0);
    chk("t2.novl_cnt", m_cnt, 1);
    finish_run();

    // 3: gaps between valid bits
    start_tx();
    feed(16'(PAT_10010), 5, 1);
    chk("t3.cnt", m_cnt, 1);
    finish_run();

    // 4: illegal lengths after reset, start ignored, then legal config
    async_reset();
    cfg_tx(8'h12, 0, 0);
    chk("t4.err0", m_err, 1);
    cfg_tx(8'h12, 9, 0);
    chk("t4.err9", m_err, 1);
    start_tx();
    chk("t4.idle", m_busy, 0);
    cfg_tx(8'h12, 5, 0);
    start_tx();
    chk("t4.busy", m_busy, 1);
    finish_run();

    // 5: hit limit of 2 on the limited instance
    start_tx();
    feed(16'(PAT_10010), 5, 0);
    feed(16'(PAT_10010), 5, 0);
    feed(16'(PAT_10010), 5, 0);
    chk("t5.lim_cnt", l_cnt, 2);
    chk("t5.main_cnt", m_cnt, 3);
    chk("t5.lim_idle", l_ready, 1);
    finish_run();

    // 6: reset mid-pattern, config lost, partial pattern never matches
    start_tx();
    feed(16'b100, 3, 0);
    async_reset();
    start_tx();
    chk("t6.unloaded", m_busy, 0);
    cfg_tx(8'h12, 5, 0);
    start_tx();
    feed(16'b010, 3, 0);
    chk("t6.nomatch", m_cnt, 0);
    finish_run();

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cfg_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) begin
        cfg_pattern = 8'h12; cfg_len = LW'(5);
      end else begin
        cfg_pattern = 8'($urandom); cfg_len = LW'($urandom_range(0, 9));
      end
      cfg_overlap = 1'($urandom);
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 39) == 0);
      data_valid  = ($urandom_range(0, 3) != 0);
      data        = 1'($urandom);
      step();
    end
    idle_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
